// File: rtl/t5_dwb_sram.sv
// Wishbone-classic word RAM for the t5_rv32i data port: byte-lane writes, fixed wait states,
// one-cycle ack pulse and an err pulse on byte selects that are not naturally aligned.
module t5_dwb_sram #(
  parameter int unsigned AW   = 10,
  parameter int unsigned WAIT = 0,
  parameter string       INIT = ""
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_ena,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_dto,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  output logic        dwb_err
);

  localparam int unsigned Depth    = 2 ** AW;
  localparam logic [3:0]  WaitInit = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dti_q, dti_d;
  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] word_idx;
  logic          sel_legal;
  logic          enter_resp;
  logic          mem_we;
  logic          unused_adr;

  // Upper address bits alias onto the RAM.
  assign word_idx   = dwb_adr[AW-1:0];
  assign unused_adr = ^dwb_adr[29:AW];

  always_comb begin
    sel_legal = 1'b0;
    case (dwb_sel)
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_legal = 1'b1;
      default:                                  sel_legal = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dti_q   <= 32'd0;
    end else if (sys_ena) begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dti_q   <= dti_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dwb_stb) state_d = (WAIT == 0) ? StResp : StWait;
      end
      StWait: begin
        if (!dwb_stb)            state_d = StIdle;
        else if (wcnt_q == 4'd0) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dti_d      = 32'd0;
    enter_resp = (state_d == StResp) && (state_q != StResp);
    if (state_q == StIdle && dwb_stb) begin
      wcnt_d = WaitInit;
    end else if (state_q == StWait && dwb_stb && wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
    if (enter_resp) begin
      if (sel_legal) begin
        ack_d = 1'b1;
        if (!dwb_wre) dti_d = mem_q[word_idx];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Commit on the edge leaving RESP so an aborted or reset-killed write never lands.
  assign mem_we = sys_ena && (state_q == StResp) && ack_q && dwb_stb && dwb_wre;

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dwb_sel[i]) mem_q[word_idx][8*i +: 8] <= dwb_dto[8*i +: 8];
      end
    end
  end

  assign dwb_dti = dti_q;
  assign dwb_ack = ack_q;
  assign dwb_err = err_q;

endmodule
